// File: rtl/baud_tick_gen.sv
// Baud-rate tick generator for a UART. It produces an oversampled receive
// tick, a once-per-bit transmit tick and a bit-rate square wave. A rate
// change requested while running waits for the next bit boundary.
module baud_tick_gen #(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DIV_W      = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [2:0]       baud_sel,
  input  logic             use_override,
  input  logic [DIV_W-1:0] div_override,
  output logic             rx_tick,
  output logic             tx_tick,
  output logic             baud_clk,
  output logic             rate_ack
);

  localparam int unsigned OS_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;

  // Stop elaboration on an oversample ratio that cannot split a bit into two halves
  if ((OVERSAMPLE < 2) || ((OVERSAMPLE % 2) != 0)) begin : g_bad_oversample
    $error("baud_tick_gen: OVERSAMPLE must be even and >= 2");
  end

  // Clocks per rx_tick for a given baud rate, rounded half up
  function automatic logic [DIV_W-1:0] calc_div(input longint unsigned rate);
    longint unsigned den;
    longint unsigned quo;
    den = rate * 64'(OVERSAMPLE);
    quo = (64'(CLK_HZ) * 64'd2 + den) / (den * 64'd2);
    return DIV_W'(quo);
  endfunction

  localparam logic [DIV_W-1:0] DIV_1200   = calc_div(64'd1200);
  localparam logic [DIV_W-1:0] DIV_2400   = calc_div(64'd2400);
  localparam logic [DIV_W-1:0] DIV_4800   = calc_div(64'd4800);
  localparam logic [DIV_W-1:0] DIV_9600   = calc_div(64'd9600);
  localparam logic [DIV_W-1:0] DIV_19200  = calc_div(64'd19200);
  localparam logic [DIV_W-1:0] DIV_38400  = calc_div(64'd38400);
  localparam logic [DIV_W-1:0] DIV_57600  = calc_div(64'd57600);
  localparam logic [DIV_W-1:0] DIV_115200 = calc_div(64'd115200);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [OS_W-1:0]  os_q, os_d;
  logic [DIV_W-1:0] active_div_q, active_div_d;
  logic             rx_tick_q, rx_tick_d;
  logic             tx_tick_q, tx_tick_d;
  logic             baud_clk_q, baud_clk_d;
  logic             rate_ack_q, rate_ack_d;

  logic [DIV_W-1:0] table_div_c;
  logic [DIV_W-1:0] req_div_c;
  logic             tick_c;
  logic             os_last_c;
  logic             os_half_c;
  logic             rate_diff_c;

  // Requested divisor: table or override, with zero promoted to one
  always_comb begin
    table_div_c = DIV_9600;
    case (baud_sel)
      3'd0: table_div_c = DIV_1200;
      3'd1: table_div_c = DIV_2400;
      3'd2: table_div_c = DIV_4800;
      3'd3: table_div_c = DIV_9600;
      3'd4: table_div_c = DIV_19200;
      3'd5: table_div_c = DIV_38400;
      3'd6: table_div_c = DIV_57600;
      3'd7: table_div_c = DIV_115200;
    endcase
    req_div_c = use_override ? div_override : table_div_c;
    if (req_div_c == '0) begin
      req_div_c = DIV_W'(1);
    end
  end

  // Next-state logic for counters, ticks and rate switching
  always_comb begin
    cnt_d        = cnt_q;
    os_d         = os_q;
    active_div_d = active_div_q;
    rx_tick_d    = 1'b0;
    tx_tick_d    = 1'b0;
    baud_clk_d   = baud_clk_q;
    rate_ack_d   = 1'b0;

    tick_c      = enable && (cnt_q == (active_div_q - DIV_W'(1)));
    os_last_c   = (os_q == OS_W'(OVERSAMPLE - 1));
    os_half_c   = (os_q == OS_W'((OVERSAMPLE / 2) - 1));
    rate_diff_c = (req_div_c != active_div_q);

    if (reset) begin
      cnt_d        = '0;
      os_d         = '0;
      baud_clk_d   = 1'b0;
      active_div_d = req_div_c;
    end else if (!enable) begin
      // Idle: counters parked, rate tracks the request immediately
      cnt_d        = '0;
      os_d         = '0;
      baud_clk_d   = 1'b0;
      active_div_d = req_div_c;
      rate_ack_d   = rate_diff_c;
    end else if (tx_tick_q && rate_diff_c) begin
      // Bit boundary: switch to the latest request and restart the bit
      cnt_d        = '0;
      os_d         = '0;
      baud_clk_d   = 1'b0;
      active_div_d = req_div_c;
      rate_ack_d   = 1'b1;
    end else begin
      rx_tick_d = tick_c;
      tx_tick_d = tick_c && os_last_c;
      if (tick_c) begin
        cnt_d = '0;
        os_d  = os_last_c ? '0 : os_q + OS_W'(1);
        if (os_last_c || os_half_c) begin
          baud_clk_d = ~baud_clk_q;
        end
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end
  end

  // State and output registers
  always_ff @(posedge clock) begin
    cnt_q        <= cnt_d;
    os_q         <= os_d;
    active_div_q <= active_div_d;
    rx_tick_q    <= rx_tick_d;
    tx_tick_q    <= tx_tick_d;
    baud_clk_q   <= baud_clk_d;
    rate_ack_q   <= rate_ack_d;
  end

  assign rx_tick  = rx_tick_q;
  assign tx_tick  = tx_tick_q;
  assign baud_clk = baud_clk_q;
  assign rate_ack = rate_ack_q;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Self-checking bench for baud_tick_gen at default parameters.
module tb_baud_tick_gen;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic [2:0]  baud_sel;
  logic        use_override;
  logic [15:0] div_override;
  logic        rx_tick;
  logic        tx_tick;
  logic        baud_clk;
  logic        rate_ack;

  int n_pass  = 0;
  int n_total = 0;
  int prev_div;

  baud_tick_gen dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .baud_sel    (baud_sel),
    .use_override(use_override),
    .div_override(div_override),
    .rx_tick     (rx_tick),
    .tx_tick     (tx_tick),
    .baud_clk    (baud_clk),
    .rate_ack    (rate_ack)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit use_ov;
    int div_ov;
    int sel;
    int exp_div;
    bit do_tx;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Enable from idle and measure tick timing relative to the first enabled cycle
  task automatic run_rate(input string tag, input int div, input bit do_tx);
    int first_rx, second_rx, first_tx, second_tx, b_rise, b_fall, acks, limit;
    first_rx = -1; second_rx = -1; first_tx = -1; second_tx = -1;
    b_rise = -1; b_fall = -1; acks = 0;
    limit = do_tx ? 32 * div + 8 : 2 * div + 8;
    enable = 1'b1;
    for (int t = 1; t <= limit; t++) begin
      step();
      if (rx_tick) begin
        if (first_rx < 0) first_rx = t;
        else if (second_rx < 0) second_rx = t;
      end
      if (tx_tick) begin
        if (first_tx < 0) first_tx = t;
        else if (second_tx < 0) second_tx = t;
      end
      if (baud_clk && b_rise < 0) b_rise = t;
      if (!baud_clk && b_rise >= 0 && b_fall < 0) b_fall = t;
      if (rate_ack) acks++;
      if (second_rx >= 0 && (!do_tx || (second_tx >= 0 && b_fall >= 0))) break;
    end
    check({tag, " first_rx"}, first_rx, div);
    check({tag, " rx_period"}, second_rx - first_rx, div);
    check({tag, " run_ack"}, acks, 0);
    if (do_tx) begin
      check({tag, " first_tx"}, first_tx, 16 * div);
      check({tag, " tx_period"}, second_tx - first_tx, 16 * div);
      check({tag, " baud_rise"}, b_rise, 8 * div);
      check({tag, " baud_high"}, b_fall - b_rise, 8 * div);
    end
    enable = 1'b0;
    step();
    step();
  endtask

  initial begin
    int acks, busy, old_rx, bad_rx, tx1, tx2, nrx1, nrx2, ack_t, first_rx;

    vecs[0]  = '{0, 0, 0, 2604, 0};
    vecs[1]  = '{0, 0, 1, 1302, 0};
    vecs[2]  = '{0, 0, 2, 651,  0};
    vecs[3]  = '{0, 0, 3, 326,  1};
    vecs[4]  = '{0, 0, 4, 163,  0};
    vecs[5]  = '{0, 0, 5, 81,   0};
    vecs[6]  = '{0, 0, 6, 54,   0};
    vecs[7]  = '{0, 0, 7, 27,   1};
    vecs[8]  = '{1, 0, 7, 1,    1};
    vecs[9]  = '{1, 1, 7, 1,    1};
    vecs[10] = '{1, 5, 7, 5,    1};

    reset = 1'b1; enable = 1'b0; baud_sel = 3'd3;
    use_override = 1'b0; div_override = 16'd0;
    step(); step(); step();
    check("reset rx_tick", int'(rx_tick), 0);
    check("reset tx_tick", int'(tx_tick), 0);
    check("reset baud_clk", int'(baud_clk), 0);
    check("reset rate_ack", int'(rate_ack), 0);
    reset = 1'b0;
    step();
    prev_div = 326;

    // Rate table sweep and override divisors
    for (int i = 0; i < 11; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      use_override = vecs[i].use_ov;
      div_override = 16'(vecs[i].div_ov);
      baud_sel     = 3'(vecs[i].sel);
      acks = 0; busy = 0;
      for (int c = 0; c < 3; c++) begin
        step();
        if (rate_ack) acks++;
        if (rx_tick || tx_tick || baud_clk) busy++;
      end
      check({tag, " idle_ack"}, acks, (vecs[i].exp_div != prev_div) ? 1 : 0);
      check({tag, " idle_out"}, busy, 0);
      prev_div = vecs[i].exp_div;
      run_rate(tag, vecs[i].exp_div, vecs[i].do_tx);
    end

    // Mid-bit request 9600 -> 19200 -> 38400: only the last applies at the bit boundary
    use_override = 1'b0; baud_sel = 3'd3;
    step(); step();
    enable = 1'b1;
    old_rx = 0; bad_rx = 0; tx1 = -1; tx2 = -1; nrx1 = -1; nrx2 = -1;
    acks = 0; ack_t = -1;
    for (int t = 1; t <= 6600; t++) begin
      step();
      if (t == 1000) baud_sel = 3'd4;
      if (t == 1500) baud_sel = 3'd5;
      if (rx_tick) begin
        if (tx1 < 0) begin
          old_rx++;
          if (t % 326 != 0) bad_rx++;
        end else if (nrx1 < 0) nrx1 = t;
        else if (nrx2 < 0) nrx2 = t;
      end
      if (tx_tick) begin
        if (tx1 < 0) tx1 = t;
        else if (tx2 < 0) tx2 = t;
      end
      if (rate_ack) begin
        acks++;
        if (ack_t < 0) ack_t = t;
      end
    end
    check("chg old_rx_count", old_rx, 16);
    check("chg old_rx_align", bad_rx, 0);
    check("chg tx_at_switch", tx1, 5216);
    check("chg ack_time", ack_t, 5217);
    check("chg ack_count", acks, 1);
    check("chg new_rx1", nrx1, 5298);
    check("chg new_rx2", nrx2 - nrx1, 81);
    check("chg new_tx", tx2, 6513);

    // Drop enable mid-bit, then re-enable
    for (int t = 0; t < 100; t++) step();
    enable = 1'b0;
    busy = 0;
    for (int t = 0; t < 20; t++) begin
      step();
      if (rx_tick || tx_tick || baud_clk || rate_ack) busy++;
    end
    check("dis outputs_zero", busy, 0);
    run_rate("reen", 81, 1'b0);

    // One-cycle reset mid-bit with enable held high
    enable = 1'b1;
    for (int t = 0; t < 50; t++) step();
    reset = 1'b1;
    step();
    check("rst mid outputs", int'({rx_tick, tx_tick, baud_clk, rate_ack}), 0);
    reset = 1'b0;
    first_rx = -1; acks = 0;
    for (int t = 1; t <= 200; t++) begin
      step();
      if (rate_ack) acks++;
      if (rx_tick && first_rx < 0) first_rx = t;
    end
    check("rst first_rx", first_rx, 81);
    check("rst ack", acks, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/baud_tick_gen.md
BAUD_TICK_GEN -- requirements
Module: baud_tick_gen

Interface
REQ-001 Parameter CLK_HZ, default 50000000: system clock frequency in Hz, used for elaboration-time divisor calculation.
REQ-002 Parameter OVERSAMPLE, default 16: rx_tick pulses per bit period; SHALL be even and >= 2; elaboration SHALL fail otherwise.
REQ-003 Parameter DIV_W, default 16: width of the divisor and prescale counter.
REQ-004 clock  in  1  system clock; all logic on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 enable  in  1  run the tick generator when high; hold it idle when low.
REQ-007 baud_sel  in  3  rate select: 0=1200, 1=2400, 2=4800, 3=9600, 4=19200, 5=38400, 6=57600, 7=115200.
REQ-008 use_override  in  1  when high, div_override replaces the table divisor.
REQ-009 div_override  in  DIV_W  raw prescale divisor, in clocks per rx_tick.
REQ-010 rx_tick  out  1  one-cycle pulse at OVERSAMPLE x baud, for the receiver sampler.
REQ-011 tx_tick  out  1  one-cycle pulse once per bit period, for the transmitter.
REQ-012 baud_clk  out  1  square wave with period of one bit and near-50% duty cycle.
REQ-013 rate_ack  out  1  one-cycle pulse when a new divisor becomes active.

Function
REQ-014 Table divisor SHALL be computed at elaboration: div(r) = round(CLK_HZ / (r * OVERSAMPLE)), rounding half up. At the defaults, 9600 gives 326 and 115200 gives 27.
REQ-015 Requested divisor SHALL be div_override when use_override=1, otherwise the table divisor for baud_sel; a request value of 0 SHALL be treated as 1.
REQ-016 Prescale counter SHALL count 0..active_div-1.
REQ-017 rx_tick SHALL assert in the cycle the prescale counter equals active_div-1; the counter then wraps to 0.
REQ-018 With active_div=1, rx_tick SHALL be high every enabled cycle.
REQ-019 Oversample counter SHALL count rx_ticks 0..OVERSAMPLE-1.
REQ-020 tx_tick SHALL assert coincident with the rx_tick that wraps the oversample counter from OVERSAMPLE-1 to 0.
REQ-021 baud_clk SHALL toggle coincident with every rx_tick that wraps the oversample counter to 0 or to OVERSAMPLE/2.
REQ-022 baud_clk SHALL be low during the first half of each bit period.
REQ-023 Rate change while enable=1: a requested divisor differing from active_div SHALL be held pending.
REQ-024 A pending divisor SHALL be applied only at the clock edge ending a cycle in which tx_tick=1.
REQ-025 Both counters SHALL restart from 0 on a rate change; no partial bit at the new rate SHALL occur.
REQ-026 If the request changes again before application, the latest value SHALL win; intermediate values SHALL be discarded.
REQ-027 Rate change while enable=0: active_div SHALL load the requested divisor every cycle.
REQ-028 With enable=0: both counters held at 0; rx_tick, tx_tick and baud_clk held 0.
REQ-029 Enable rising edge: first rx_tick SHALL occur active_div cycles after the first cycle enable is high.
REQ-030 Enable falling mid-bit: counters cleared next edge; the partial bit is abandoned with no tick emitted.
REQ-031 rate_ack SHALL pulse for exactly one cycle, in the cycle after active_div changes value.
REQ-032 rate_ack SHALL NOT pulse when the applied value equals the previous active_div.
REQ-033 All outputs SHALL be registered; no combinational input-to-output path SHALL exist.

Reset
REQ-034 While reset=1 at a clock edge: counters <= 0; rx_tick, tx_tick, baud_clk, rate_ack <= 0.
REQ-035 While reset=1: active_div <= requested divisor; any pending change is cleared.
REQ-036 Reset SHALL take priority over enable and any pending rate change.
REQ-037 Reset asserted mid-bit SHALL abort the bit; the first rx_tick after release occurs active_div cycles after release.

Verification
REQ-038 Defaults, baud_sel=3, enable=1 after reset -> rx_tick every 326 clocks; tx_tick every 5216 clocks; baud_clk high for 2608 clocks of each 5216.
REQ-039 baud_sel=7, use_override=0 -> rx_tick every 27 clocks, tx_tick every 432 clocks; sweeping baud_sel over all 8 rates -> periods match REQ-014.
REQ-040 use_override=1, div_override=0, then 1, then 5 -> rx_tick every cycle, every cycle, every 5th cycle; tx_tick every 16, 16, 80 cycles.
REQ-041 Running at 9600, baud_sel -> 4 mid-bit, then -> 5 before the next tx_tick -> the old rate continues to that tx_tick; then 38400 applies (divisor 81), rate_ack pulses once, and rate 4 never becomes active.
REQ-042 enable=0 mid-bit, then re-enabled -> all outputs 0 while disabled; first rx_tick exactly active_div cycles after re-enable.
REQ-043 reset=1 for one cycle mid-bit with enable held at 1 -> outputs 0 the next cycle; rx_tick resumes active_div cycles after release; rate_ack remains 0.
